// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: shared MIPS constants, ALU control encodings and the EX control bundle with its NOP value
package id_ex_pipe_reg_pkg;
  localparam int REG_W = 5;
  localparam int ALUC_W = 4;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_JR = 6'b001000;
  typedef enum logic [ALUC_W-1:0] {
    ALUC_ADD = 4'b0000,
    ALUC_AND = 4'b0001,
    ALUC_XOR = 4'b0010,
    ALUC_SLL = 4'b0011,
    ALUC_SUB = 4'b0100,
    ALUC_OR  = 4'b0101,
    ALUC_LUI = 4'b0110,
    ALUC_SRL = 4'b0111,
    ALUC_SRA = 4'b1111
  } aluc_e;
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
    logic aluimm;
    logic shift;
    logic jal;
    logic lw;
  } ctrl_t;
  localparam int CTRL_W = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: ID/EX bundle; master = decode/stall side driving id_* and en/stall/flush, slave = the pipe register driving ex_* and bubble_cnt
interface id_ex_pipe_reg_if
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DW = 32,
  parameter int CNT_W = 16
);
  logic en, stall, flush;
  logic [DW-1:0] id_pc4, id_qa, id_qb, id_imm;
  logic [REG_W-1:0] id_sa, id_td;
  logic [ALUC_W-1:0] id_aluc;
  logic id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_jal, id_lw;
  logic [DW-1:0] ex_pc4, ex_qa, ex_qb, ex_imm;
  logic [REG_W-1:0] ex_sa, ex_td;
  logic [ALUC_W-1:0] ex_aluc;
  logic ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_shift, ex_jal, ex_lw;
  logic ex_valid;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output en, stall, flush, id_pc4, id_qa, id_qb, id_imm, id_sa, id_td, id_aluc,
           id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_jal, id_lw,
    input  ex_pc4, ex_qa, ex_qb, ex_imm, ex_sa, ex_td, ex_aluc, ex_wreg, ex_m2reg,
           ex_wmem, ex_aluimm, ex_shift, ex_jal, ex_lw, ex_valid, bubble_cnt
  );
  modport slave (
    input  en, stall, flush, id_pc4, id_qa, id_qb, id_imm, id_sa, id_td, id_aluc,
           id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_jal, id_lw,
    output ex_pc4, ex_qa, ex_qb, ex_imm, ex_sa, ex_td, ex_aluc, ex_wreg, ex_m2reg,
           ex_wmem, ex_aluimm, ex_shift, ex_jal, ex_lw, ex_valid, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg_field.sv
// pipe_field_reg: W-bit field register; clk, rst_n (sync active-low), en_i hold when 0, clr_i load zero over d_i, q_o output
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = !en_i ? q_q : clr_i ? '0 : d_i;
  always_ff @(posedge clk)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX register; clk, rst_n (sync active-low), bus slave (en/stall/flush, id_* in, ex_*/ex_valid/bubble_cnt out); macro STALL_COUNT_EN adds a saturating bubble counter
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DW = 32,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_pipe_reg_if.slave bus
);
  logic clr;
  ctrl_t id_ctrl, ex_ctrl;
  assign clr = bus.flush | bus.stall;
  assign id_ctrl = '{bus.id_wreg, bus.id_m2reg, bus.id_wmem, bus.id_aluimm, bus.id_shift, bus.id_jal, bus.id_lw};
  pipe_field_reg #(.W(4*DW)) u_data (
    .clk(clk), .rst_n(rst_n), .en_i(bus.en), .clr_i(clr),
    .d_i({bus.id_pc4, bus.id_qa, bus.id_qb, bus.id_imm}),
    .q_o({bus.ex_pc4, bus.ex_qa, bus.ex_qb, bus.ex_imm})
  );
  pipe_field_reg #(.W(2*REG_W+ALUC_W)) u_fld (
    .clk(clk), .rst_n(rst_n), .en_i(bus.en), .clr_i(clr),
    .d_i({bus.id_sa, bus.id_td, bus.id_aluc}),
    .q_o({bus.ex_sa, bus.ex_td, bus.ex_aluc})
  );
  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .en_i(bus.en), .clr_i(clr),
    .d_i(id_ctrl), .q_o(ex_ctrl)
  );
  pipe_field_reg #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en_i(bus.en), .clr_i(clr),
    .d_i(1'b1), .q_o(bus.ex_valid)
  );
  assign {bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_aluimm, bus.ex_shift, bus.ex_jal, bus.ex_lw} = ex_ctrl;
`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // flush+stall is a flush bubble, not a load-use bubble
  always_comb cnt_d = (bus.en && bus.stall && !bus.flush && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.bubble_cnt = cnt_q;
`else
  assign bus.bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
`ifdef STALL_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  localparam logic [148:0] VA = {32'h0000_0104, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0,
                                 5'd3, 5'd8, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [148:0] VB = {32'h0000_0200, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0000_1234,
                                 5'd31, 5'd31, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [148:0] VC = {32'hCAFE_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_FFFF,
                                 5'd1, 5'd2, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  id_ex_pipe_reg_if #(.DW(32), .CNT_W(2)) bus ();
  id_ex_pipe_reg #(.DW(32), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [149:0] obs;
  assign obs = {bus.ex_pc4, bus.ex_qa, bus.ex_qb, bus.ex_imm, bus.ex_sa, bus.ex_td, bus.ex_aluc,
                bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_aluimm, bus.ex_shift, bus.ex_jal,
                bus.ex_lw, bus.ex_valid};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [148:0] v);
    {bus.id_pc4, bus.id_qa, bus.id_qb, bus.id_imm, bus.id_sa, bus.id_td, bus.id_aluc,
     bus.id_wreg, bus.id_m2reg, bus.id_wmem, bus.id_aluimm, bus.id_shift, bus.id_jal, bus.id_lw} = v;
  endtask
  task automatic chk(input string tag, input logic [149:0] o, input logic [149:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_cnt(input string tag, input int n);
    chk(tag, 150'(bus.bubble_cnt), CE ? 150'(n) : 150'(0));
  endtask
  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    drive('1);
    tick();
    chk("reset_all", obs, '0);
    chk_cnt("reset_cnt", 0);
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(VA);
    tick();
    chk("pass_pc4", 150'(bus.ex_pc4), 150'(32'h104));
    chk("pass_td", 150'(bus.ex_td), 150'(8));
    chk("pass_wreg_valid", 150'({bus.ex_wreg, bus.ex_lw, bus.ex_valid}), 150'(3'b111));
    chk("pass_all_a", obs, {VA, 1'b1});
    bus.stall = 1'b1;
    drive(VB);
    tick();
    chk("lu_td_lw_wreg_valid", 150'({bus.ex_td, bus.ex_lw, bus.ex_wreg, bus.ex_valid}), 150'(0));
    chk("lu_bubble_all", obs, '0);
    chk_cnt("lu_cnt", 1);
    bus.stall = 1'b0;
    tick();
    chk("pass_all_b", obs, {VB, 1'b1});
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    chk("fs_bubble", obs, '0);
    chk_cnt("fs_cnt", 1);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(VC);
    tick();
    chk("pass_all_c", obs, {VC, 1'b1});
    bus.flush = 1'b1;
    tick();
    chk("flush_bubble", obs, '0);
    chk_cnt("flush_cnt", 1);
    bus.flush = 1'b0;
    drive(VA);
    tick();
    chk("pre_freeze", obs, {VA, 1'b1});
    bus.en = 1'b0;
    bus.stall = 1'b1;
    drive(VB);
    tick();
    chk("freeze1", obs, {VA, 1'b1});
    chk_cnt("freeze1_cnt", 1);
    drive(VC);
    bus.flush = 1'b1;
    tick();
    chk("freeze2", obs, {VA, 1'b1});
    bus.flush = 1'b0;
    drive(~VA);
    tick();
    chk("freeze3", obs, {VA, 1'b1});
    chk_cnt("freeze3_cnt", 1);
    bus.en = 1'b1;
    bus.stall = 1'b0;
    drive(VB);
    tick();
    chk("resume", obs, {VB, 1'b1});
    chk_cnt("resume_cnt", 1);
    rst_n = 1'b0;
    bus.en = 1'b0;
    tick();
    chk("rst_over_en", obs, '0);
    chk_cnt("rst_over_en_cnt", 0);
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.stall = 1'b1;
    tick();
    chk_cnt("sat1", 1);
    tick();
    chk_cnt("sat2", 2);
    tick();
    chk_cnt("sat3", 3);
    tick();
    chk_cnt("sat4", 3);
    tick();
    chk_cnt("sat5", 3);
    chk("sat_bubble", obs, '0);
    rst_n = 1'b0;
    tick();
    chk_cnt("mid_rst", 0);
    rst_n = 1'b1;
    tick();
    chk_cnt("after_rst", 1);
    bus.stall = 1'b0;
    drive(VC);
    tick();
    chk("final_load", obs, {VC, 1'b1});
    chk_cnt("final_cnt", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
